// File: rtl/scope_pkg.sv
// Shared definitions for the scope digital core's SPI master: slave-select
// codes, the transaction FSM states and the select decoder.
package scope_pkg;

  localparam logic [2:0] SS_TRIG = 3'b000;
  localparam logic [2:0] SS_CH1  = 3'b001;
  localparam logic [2:0] SS_CH2  = 3'b010;
  localparam logic [2:0] SS_CH3  = 3'b011;
  localparam logic [2:0] SS_EEP  = 3'b100;

  typedef enum logic [1:0] {IDLE, FRONT, SHIFT} spi_state_t;

  // Active-low one-cold select vector; unused codes select nobody.
  function automatic logic [4:0] ss_decode(input logic [2:0] sel);
    logic [4:0] ss_n;
    ss_n = '1;
    case (sel)
      SS_TRIG: ss_n[0] = 1'b0;
      SS_CH1:  ss_n[1] = 1'b0;
      SS_CH2:  ss_n[2] = 1'b0;
      SS_CH3:  ss_n[3] = 1'b0;
      SS_EEP:  ss_n[4] = 1'b0;
      default: ss_n = '1;
    endcase
    return ss_n;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period counter producing SCLK for the SPI master. rise_nxt_o/fall_nxt_o
// pulse in the cycle before SCLK changes, so the FSM acts on the same edge.
module spi_sclk_gen #(
  parameter int unsigned H = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic hold_low_i,
  output logic rise_nxt_o,
  output logic fall_nxt_o,
  output logic sclk_o
);

  localparam int unsigned CW = $clog2(H + 1);

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          tick;

  // Counter reloads H (not H-1) while idle: the first phase after enable is
  // one clk longer, which accounts for the accepting edge in the latency.
  assign tick       = en_i && (cnt_q == '0);
  assign rise_nxt_o = tick && !sclk_q;
  assign fall_nxt_o = tick && sclk_q;
  assign sclk_o     = sclk_q;

  // Half-period down-counter and SCLK toggle; hold_low_i masks the rise that
  // would follow the back porch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= CW'(H);
      sclk_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= CW'(H);
      sclk_q <= 1'b0;
    end else begin
      if (cnt_q == '0) cnt_q <= CW'(H - 1);
      else             cnt_q <= cnt_q - CW'(1);
      if (rise_nxt_o && !hold_low_i) sclk_q <= 1'b1;
      else if (fall_nxt_o)           sclk_q <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_mstr.sv
// SPI master (mode 0) for 16-bit config transactions to the trigger DAC,
// AFE gain pots and calibration EEPROM. Shifts MSB-first, returns MISO word.
module spi_mstr
  import scope_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 32,
  parameter int unsigned NUM_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wrt_SPI,
  input  logic [NUM_BITS-1:0] SPI_data,
  input  logic [2:0]          ss,
  input  logic                MISO,
  output logic                SCLK,
  output logic                MOSI,
  output logic [4:0]          SS_n,
  output logic                SPI_done,
  output logic [NUM_BITS-1:0] rd_data,
  output logic [7:0]          EEP_data
);

  localparam int unsigned H  = SCLK_DIV / 2;
  localparam int unsigned BW = $clog2(NUM_BITS);

  spi_state_t          state_q;
  logic [NUM_BITS-1:0] shft_q;
  logic [NUM_BITS-1:0] rd_q;
  logic [BW-1:0]       bit_cnt_q;
  logic                porch_q;
  logic [4:0]          ss_n_q;
  logic                mosi_q;
  logic                done_q;
  logic                miso_s1_q, miso_s2_q, miso_smpl_q;
  logic                rise_nxt, fall_nxt;

  spi_sclk_gen #(.H(H)) u_sclk (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (state_q != IDLE),
    .hold_low_i (porch_q),
    .rise_nxt_o (rise_nxt),
    .fall_nxt_o (fall_nxt),
    .sclk_o     (SCLK)
  );

  // MISO two-flop synchronizer and capture on the SCLK rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
      miso_smpl_q <= 1'b0;
    end else begin
      miso_s1_q <= MISO;
      miso_s2_q <= miso_s1_q;
      if (rise_nxt) miso_smpl_q <= miso_s2_q;
    end
  end

  // Transaction FSM with shift register, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shft_q    <= '0;
      rd_q      <= '0;
      bit_cnt_q <= '0;
      porch_q   <= 1'b0;
      ss_n_q    <= '1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wrt_SPI) begin
            shft_q    <= SPI_data;
            mosi_q    <= SPI_data[NUM_BITS-1];
            ss_n_q    <= ss_decode(ss);
            done_q    <= 1'b0;
            bit_cnt_q <= '0;
            porch_q   <= 1'b0;
            state_q   <= FRONT;
          end
        end
        FRONT: begin
          if (rise_nxt) state_q <= SHIFT;
        end
        SHIFT: begin
          if (fall_nxt) begin
            shft_q    <= {shft_q[NUM_BITS-2:0], miso_smpl_q};
            mosi_q    <= shft_q[NUM_BITS-2];
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(NUM_BITS - 1)) porch_q <= 1'b1;
          end
          // End of the back porch: the suppressed rise marks completion.
          if (porch_q && rise_nxt) begin
            ss_n_q  <= '1;
            done_q  <= 1'b1;
            rd_q    <= shft_q;
            porch_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MOSI     = mosi_q;
  assign SS_n     = ss_n_q;
  assign SPI_done = done_q;
  assign rd_data  = rd_q;
  assign EEP_data = rd_q[7:0];

endmodule

// File: tb/tb_spi_mstr.sv
// Directed bench for spi_mstr: mode-0 slave model, MOSI capture, latency and
// select checks with hand-computed expectations.
module tb_spi_mstr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt_SPI;
  logic [15:0] SPI_data;
  logic [2:0]  ss;
  logic        MISO;
  logic        SCLK;
  logic        MOSI;
  logic [4:0]  SS_n;
  logic        SPI_done;
  logic [15:0] rd_data;
  logic [7:0]  EEP_data;

  int n_cmp = 0;
  int n_err = 0;

  // slave model / monitor state
  logic [15:0] resp_w = 16'h0000;
  logic [15:0] mosi_cap = 16'h0000;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int fall_base = 0;
  int sclk_viol = 0;

  spi_mstr #(.SCLK_DIV(32), .NUM_BITS(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrt_SPI  (wrt_SPI),
    .SPI_data (SPI_data),
    .ss       (ss),
    .MISO     (MISO),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .SS_n     (SS_n),
    .SPI_done (SPI_done),
    .rd_data  (rd_data),
    .EEP_data (EEP_data)
  );

  always #5 clk = ~clk;

  always @(posedge SCLK) begin
    rise_cnt <= rise_cnt + 1;
    mosi_cap <= {mosi_cap[14:0], MOSI};
  end

  always @(negedge SCLK) fall_cnt <= fall_cnt + 1;

  always @(negedge clk) if (SS_n == 5'h1f && SCLK === 1'b1) sclk_viol <= sclk_viol + 1;

  // slave presents bit 15 before the first rise, next bit after every fall
  always_comb begin
    int idx;
    idx = fall_cnt - fall_base;
    MISO = (idx >= 0 && idx < 16) ? resp_w[15 - idx] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts a transaction (accepted on the next edge) and waits for SPI_done.
  task automatic run_xfer(input logic [15:0] data, input logic [2:0] sel,
                          input logic [15:0] resp, input logic [4:0] exp_ssn,
                          input int pulse_at, input int reset_at,
                          output int lat, output int ss_bad, output int rises,
                          output logic done_after_acc, output logic [4:0] ss_at_done);
    int rise_base;
    resp_w    = resp;
    fall_base = fall_cnt;
    rise_base = rise_cnt;
    SPI_data  = data;
    ss        = sel;
    wrt_SPI   = 1'b1;
    @(posedge clk); #1;
    wrt_SPI = 1'b0;
    done_after_acc = SPI_done;
    lat = 0;
    ss_bad = 0;
    while (lat < 1500) begin
      @(posedge clk); #1;
      lat++;
      if (lat == pulse_at) begin
        wrt_SPI  = 1'b1;
        SPI_data = ~data;
        ss       = sel ^ 3'b011;
      end else if (lat == pulse_at + 1) begin
        wrt_SPI = 1'b0;
      end
      if (lat == reset_at) break;
      if (SPI_done) break;
      if (SS_n !== exp_ssn) ss_bad++;
    end
    rises = rise_cnt - rise_base;
    ss_at_done = SS_n;
  endtask

  int lat, ss_bad, rises, viol_base;
  logic dacc;
  logic [4:0] ssd;

  initial begin
    rst_n = 1'b0; wrt_SPI = 1'b0; SPI_data = '0; ss = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_SCLK", SCLK, 0);
    chk("rst_MOSI", MOSI, 0);
    chk("rst_SS_n", SS_n, 5'h1f);
    chk("rst_done", SPI_done, 0);
    chk("rst_rd", rd_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ch1 write
    run_xfer(16'h1305, 3'b001, 16'h5A3C, 5'b11101, 0, 0, lat, ss_bad, rises, dacc, ssd);
    chk("ch1_lat", lat, 529);
    chk("ch1_ss", ss_bad, 0);
    chk("ch1_mosi", mosi_cap, 16'h1305);
    chk("ch1_rises", rises, 16);
    chk("ch1_rd", rd_data, 16'h5A3C);
    chk("ch1_eep", EEP_data, 8'h3C);
    chk("ch1_ssdone", ssd, 5'h1f);
    repeat (4) @(posedge clk); #1;

    // EEPROM read
    run_xfer(16'h0023, 3'b100, 16'h00A7, 5'b01111, 0, 0, lat, ss_bad, rises, dacc, ssd);
    chk("eep_lat", lat, 529);
    chk("eep_ss", ss_bad, 0);
    chk("eep_mosi", mosi_cap, 16'h0023);
    chk("eep_rd", rd_data, 16'h00A7);
    chk("eep_data", EEP_data, 8'hA7);
    repeat (4) @(posedge clk); #1;

    // trigger DAC, SCLK must stay low outside the select window
    viol_base = sclk_viol;
    run_xfer(16'h1380, 3'b000, 16'h0000, 5'b11110, 0, 0, lat, ss_bad, rises, dacc, ssd);
    repeat (20) @(posedge clk); #1;
    chk("trig_ss", ss_bad, 0);
    chk("trig_rises", rises, 16);
    chk("trig_mosi", mosi_cap, 16'h1380);
    chk("trig_sclk_idle", sclk_viol - viol_base, 0);
    chk("trig_rd", rd_data, 16'h0000);

    // busy: a second wrt_SPI at clk 100 is ignored
    run_xfer(16'hC3A5, 3'b010, 16'h1234, 5'b11011, 100, 0, lat, ss_bad, rises, dacc, ssd);
    chk("busy_lat", lat, 529);
    chk("busy_ss", ss_bad, 0);
    chk("busy_mosi", mosi_cap, 16'hC3A5);
    chk("busy_rd", rd_data, 16'h1234);
    repeat (600) @(posedge clk); #1;
    chk("busy_one_done", SPI_done, 1);
    chk("busy_idle_ss", SS_n, 5'h1f);
    chk("busy_idle_sclk", SCLK, 0);

    // unused select code
    run_xfer(16'h7E81, 3'b110, 16'h0F0F, 5'b11111, 0, 0, lat, ss_bad, rises, dacc, ssd);
    chk("none_lat", lat, 529);
    chk("none_ss", ss_bad, 0);
    chk("none_ssdone", ssd, 5'h1f);

    // back-to-back: accepted in the cycle right after done
    run_xfer(16'h8001, 3'b011, 16'hA55A, 5'b10111, 0, 0, lat, ss_bad, rises, dacc, ssd);
    chk("b2b_done_drop", dacc, 0);
    chk("b2b_lat", lat, 529);
    chk("b2b_ss", ss_bad, 0);
    chk("b2b_mosi", mosi_cap, 16'h8001);
    chk("b2b_rd", rd_data, 16'hA55A);

    // reset during bit 7 (bit 7 rise is at clk 241)
    run_xfer(16'hFFFF, 3'b001, 16'h1111, 5'b11101, 0, 250, lat, ss_bad, rises, dacc, ssd);
    chk("rstm_at", lat, 250);
    chk("rstm_busy_ss", SS_n, 5'b11101);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstm_ss", SS_n, 5'h1f);
    chk("rstm_sclk", SCLK, 0);
    chk("rstm_done", SPI_done, 0);
    chk("rstm_rd", rd_data, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_xfer(16'h2468, 3'b100, 16'h00C3, 5'b01111, 0, 0, lat, ss_bad, rises, dacc, ssd);
    chk("post_lat", lat, 529);
    chk("post_ss", ss_bad, 0);
    chk("post_mosi", mosi_cap, 16'h2468);
    chk("post_eep", EEP_data, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
